peripheral_msi_master_port_ahb3: RTL and testbench

Per-master front end of the AHB3 master/slave interconnect; sits between one AHB-Lite master and the SLAVES arbitrated slave ports, directly upstream of each slave port's arbiter. Decodes each address phase to a one-hot slave select and raises HSEL towards that slave port. When not yet granted, it buffers the address phase and stalls the master. It drives can_switch so the slave ports never re-arbitrate inside locked or burst sequences, and returns the AHB two-cycle ERROR response on decode misses.

---
 rtl/peripheral_msi_master_port_ahb3.sv | 196 +++++++++++++++++++
 tb/tb_peripheral_msi_master_port_ahb3.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_msi_master_port_ahb3.sv
// Per-master AHB3 interconnect front end: address decode, grant buffering with master stall,
// can_switch generation for locked/burst sequences, and the two-cycle ERROR response on misses.
module peripheral_msi_master_port_ahb3 #(
  parameter int PLEN   = 64,
  parameter int XLEN   = 64,
  parameter int SLAVES = 5
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic                         mstHSEL,
  input  logic [PLEN-1:0]              mstHADDR,
  input  logic [XLEN-1:0]              mstHWDATA,
  output logic [XLEN-1:0]              mstHRDATA,
  input  logic                         mstHWRITE,
  input  logic [2:0]                   mstHSIZE,
  input  logic [2:0]                   mstHBURST,
  input  logic [3:0]                   mstHPROT,
  input  logic [1:0]                   mstHTRANS,
  input  logic                         mstHMASTLOCK,
  output logic                         mstHREADYOUT,
  input  logic                         mstHREADY,
  output logic                         mstHRESP,
  input  logic [SLAVES-1:0][PLEN-1:0]  slvHADDRmask,
  input  logic [SLAVES-1:0][PLEN-1:0]  slvHADDRbase,
  output logic [SLAVES-1:0]            slvHSEL,
  output logic [PLEN-1:0]              slvHADDR,
  output logic [XLEN-1:0]              slvHWDATA,
  input  logic [SLAVES-1:0][XLEN-1:0]  slvHRDATA,
  output logic                         slvHWRITE,
  output logic [2:0]                   slvHSIZE,
  output logic [2:0]                   slvHBURST,
  output logic [3:0]                   slvHPROT,
  output logic [1:0]                   slvHTRANS,
  output logic                         slvHMASTLOCK,
  output logic                         slvHREADYOUT,
  input  logic [SLAVES-1:0]            slvHREADY,
  input  logic [SLAVES-1:0]            slvHRESP,
  input  logic [SLAVES-1:0]            granted_master,
  output logic [SLAVES-1:0]            can_switch
);

  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [SLAVES-1:0] SEL_ONE = {{(SLAVES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t              state_r;
  logic [SLAVES-1:0]   data_sel_r;
  logic [SLAVES-1:0]   buf_sel_r;
  logic [PLEN-1:0]     buf_addr_r;
  logic                buf_write_r;
  logic                buf_lock_r;
  logic [2:0]          buf_size_r;
  logic [2:0]          buf_burst_r;
  logic [3:0]          buf_prot_r;

  logic [SLAVES-1:0]   hit_vec_s;
  logic [SLAVES-1:0]   hit_sel_s;
  logic                hit_any_s;
  logic                is_xfer_s;
  logic                granted_hit_s;
  logic                hold_live_s;
  logic [XLEN-1:0]     rdata_s;
  logic                ready_sel_s;
  logic                resp_sel_s;

  // Address decode; the lowest-index match wins by isolating the lowest set bit.
  always_comb begin
    hit_vec_s = '0;
    for (int s = 0; s < SLAVES; s++) begin
      hit_vec_s[s] = (((mstHADDR ^ slvHADDRbase[s]) & slvHADDRmask[s]) == {PLEN{1'b0}});
    end
    hit_sel_s     = hit_vec_s & (~hit_vec_s + SEL_ONE);
    hit_any_s     = |hit_vec_s;
    is_xfer_s     = mstHSEL & mstHTRANS[1];
    granted_hit_s = |(hit_sel_s & granted_master);
    hold_live_s   = mstHMASTLOCK | (mstHTRANS == HTRANS_SEQ) | (mstHTRANS == HTRANS_BUSY);
  end

  // Data-phase return mux selected by the one-hot data_sel register.
  always_comb begin
    rdata_s = '0;
    for (int s = 0; s < SLAVES; s++) begin
      rdata_s = rdata_s | (slvHRDATA[s] & {XLEN{data_sel_r[s]}});
    end
    ready_sel_s = |(slvHREADY & data_sel_r);
    resp_sel_s  = |(slvHRESP & data_sel_r);
  end

  // Port FSM: live forwarding, address-phase buffering while ungranted, error response.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r     <= ST_IDLE;
      data_sel_r  <= '0;
      buf_sel_r   <= '0;
      buf_addr_r  <= '0;
      buf_write_r <= 1'b0;
      buf_lock_r  <= 1'b0;
      buf_size_r  <= 3'b000;
      buf_burst_r <= 3'b000;
      buf_prot_r  <= 4'b0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mstHREADY) begin
            if (is_xfer_s && hit_any_s && granted_hit_s) begin
              data_sel_r <= hit_sel_s;
            end else if (is_xfer_s && hit_any_s) begin
              buf_sel_r   <= hit_sel_s;
              buf_addr_r  <= mstHADDR;
              buf_write_r <= mstHWRITE;
              buf_lock_r  <= mstHMASTLOCK;
              buf_size_r  <= mstHSIZE;
              buf_burst_r <= mstHBURST;
              buf_prot_r  <= mstHPROT;
              data_sel_r  <= '0;
              state_r     <= ST_WAIT;
            end else if (is_xfer_s) begin
              data_sel_r <= '0;
              state_r    <= ST_ERR1;
            end else begin
              data_sel_r <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (|(buf_sel_r & granted_master & slvHREADY)) begin
            data_sel_r <= buf_sel_r;
            state_r    <= ST_IDLE;
          end
        end
        ST_ERR1: state_r <= ST_ERR2;
        ST_ERR2: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Output steering; reset forces idle values without waiting for a clock edge.
  always_comb begin
    slvHSEL      = '0;
    slvHADDR     = mstHADDR;
    slvHWRITE    = mstHWRITE;
    slvHSIZE     = mstHSIZE;
    slvHBURST    = mstHBURST;
    slvHPROT     = mstHPROT;
    slvHTRANS    = mstHTRANS;
    slvHMASTLOCK = mstHMASTLOCK;
    mstHREADYOUT = 1'b1;
    mstHRESP     = 1'b0;
    can_switch   = '1;
    if (HRESET) begin
      slvHSEL = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          slvHSEL      = mstHSEL ? hit_sel_s : '0;
          mstHREADYOUT = (data_sel_r == '0) ? 1'b1 : ready_sel_s;
          mstHRESP     = resp_sel_s;
          can_switch   = ~(hit_sel_s & {SLAVES{mstHSEL & hold_live_s}});
        end
        ST_WAIT: begin
          slvHSEL      = buf_sel_r;
          slvHADDR     = buf_addr_r;
          slvHWRITE    = buf_write_r;
          slvHSIZE     = buf_size_r;
          slvHBURST    = buf_burst_r;
          slvHPROT     = buf_prot_r;
          slvHTRANS    = HTRANS_NONSEQ;
          slvHMASTLOCK = buf_lock_r;
          mstHREADYOUT = 1'b0;
          mstHRESP     = resp_sel_s;
          can_switch   = ~(buf_sel_r & {SLAVES{buf_lock_r}});
        end
        ST_ERR1: begin
          mstHREADYOUT = 1'b0;
          mstHRESP     = 1'b1;
        end
        ST_ERR2: begin
          mstHREADYOUT = 1'b1;
          mstHRESP     = 1'b1;
        end
        default: begin
          mstHREADYOUT = 1'b1;
        end
      endcase
    end
  end

  assign mstHRDATA    = rdata_s;
  assign slvHWDATA    = mstHWDATA;
  assign slvHREADYOUT = mstHREADYOUT;

endmodule

// File: tb/tb_peripheral_msi_master_port_ahb3.sv
// Directed bench for peripheral_msi_master_port_ahb3: decode table plus hand-written
// sequences for granted/ungranted transfers, decode miss, locked burst and mid-WAIT reset.
module tb_peripheral_msi_master_port_ahb3;

  localparam int PLEN = 64;
  localparam int XLEN = 64;
  localparam int NS   = 5;

  logic                      HCLK = 1'b0;
  logic                      HRESET;
  logic                      mstHSEL, mstHWRITE, mstHMASTLOCK, mstHREADY;
  logic [PLEN-1:0]           mstHADDR;
  logic [XLEN-1:0]           mstHWDATA, mstHRDATA;
  logic [2:0]                mstHSIZE, mstHBURST;
  logic [3:0]                mstHPROT;
  logic [1:0]                mstHTRANS;
  logic                      mstHREADYOUT, mstHRESP;
  logic [NS-1:0][PLEN-1:0]   slvHADDRmask, slvHADDRbase;
  logic [NS-1:0]             slvHSEL;
  logic [PLEN-1:0]           slvHADDR;
  logic [XLEN-1:0]           slvHWDATA;
  logic [NS-1:0][XLEN-1:0]   slvHRDATA;
  logic                      slvHWRITE, slvHMASTLOCK, slvHREADYOUT;
  logic [2:0]                slvHSIZE, slvHBURST;
  logic [3:0]                slvHPROT;
  logic [1:0]                slvHTRANS;
  logic [NS-1:0]             slvHREADY, slvHRESP, granted_master, can_switch;
  logic                      hready_low;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 HCLK = ~HCLK;

  // Single-master bus: HREADY is this port's own HREADYOUT unless held low for decode-only vectors.
  assign mstHREADY = hready_low ? 1'b0 : mstHREADYOUT;

  peripheral_msi_master_port_ahb3 #(.PLEN(PLEN), .XLEN(XLEN), .SLAVES(NS)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .mstHSEL(mstHSEL), .mstHADDR(mstHADDR), .mstHWDATA(mstHWDATA), .mstHRDATA(mstHRDATA),
    .mstHWRITE(mstHWRITE), .mstHSIZE(mstHSIZE), .mstHBURST(mstHBURST), .mstHPROT(mstHPROT),
    .mstHTRANS(mstHTRANS), .mstHMASTLOCK(mstHMASTLOCK), .mstHREADYOUT(mstHREADYOUT),
    .mstHREADY(mstHREADY), .mstHRESP(mstHRESP),
    .slvHADDRmask(slvHADDRmask), .slvHADDRbase(slvHADDRbase), .slvHSEL(slvHSEL),
    .slvHADDR(slvHADDR), .slvHWDATA(slvHWDATA), .slvHRDATA(slvHRDATA), .slvHWRITE(slvHWRITE),
    .slvHSIZE(slvHSIZE), .slvHBURST(slvHBURST), .slvHPROT(slvHPROT), .slvHTRANS(slvHTRANS),
    .slvHMASTLOCK(slvHMASTLOCK), .slvHREADYOUT(slvHREADYOUT), .slvHREADY(slvHREADY),
    .slvHRESP(slvHRESP), .granted_master(granted_master), .can_switch(can_switch)
  );

  typedef struct {
    logic        hsel;
    logic [1:0]  trans;
    logic        lock;
    logic [63:0] addr;
    logic [4:0]  exp_sel;
    logic [4:0]  exp_cs;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic hsel, input logic [1:0] trans, input logic wr,
                       input logic lock, input logic [63:0] addr);
    mstHSEL      = hsel;
    mstHTRANS    = trans;
    mstHWRITE    = wr;
    mstHMASTLOCK = lock;
    mstHADDR     = addr;
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    // decode map: 0x0xxx,0x1xxx,0x2xxx -> 0,1,2; slave 3 aliases slave 2; slave 4 is 0x40xx only
    slvHADDRbase[0] = 64'h0000; slvHADDRmask[0] = 64'hF000;
    slvHADDRbase[1] = 64'h1000; slvHADDRmask[1] = 64'hF000;
    slvHADDRbase[2] = 64'h2000; slvHADDRmask[2] = 64'hF000;
    slvHADDRbase[3] = 64'h2000; slvHADDRmask[3] = 64'hF000;
    slvHADDRbase[4] = 64'h4000; slvHADDRmask[4] = 64'hFF00;
    for (int s = 0; s < NS; s++) slvHRDATA[s] = 64'hD0 + 64'(s);
    slvHRDATA[1]   = 64'h1234;
    slvHREADY      = 5'b11111;
    slvHRESP       = 5'b00000;
    granted_master = 5'b00000;
    mstHWDATA = 64'h0; mstHSIZE = 3'b011; mstHBURST = 3'b000; mstHPROT = 4'b0011;
    hready_low = 1'b0;

    vecs[0] = '{1'b1, 2'b10, 1'b0, 64'h0010, 5'b00001, 5'b11111};
    vecs[1] = '{1'b1, 2'b10, 1'b0, 64'h1008, 5'b00010, 5'b11111};
    vecs[2] = '{1'b1, 2'b10, 1'b0, 64'h2004, 5'b00100, 5'b11111};
    vecs[3] = '{1'b1, 2'b11, 1'b0, 64'h2008, 5'b00100, 5'b11011};
    vecs[4] = '{1'b1, 2'b01, 1'b0, 64'h1000, 5'b00010, 5'b11101};
    vecs[5] = '{1'b1, 2'b10, 1'b1, 64'h4010, 5'b10000, 5'b01111};
    vecs[6] = '{1'b0, 2'b10, 1'b0, 64'h1000, 5'b00000, 5'b11111};
    vecs[7] = '{1'b1, 2'b10, 1'b0, 64'hF000, 5'b00000, 5'b11111};
    vecs[8] = '{1'b1, 2'b00, 1'b1, 64'h0000, 5'b00001, 5'b11110};
    vecs[9] = '{1'b1, 2'b10, 1'b0, 64'h4100, 5'b00000, 5'b11111};

    // reset with a locked transfer presented: outputs must still show reset values
    HRESET = 1'b1;
    drive(1'b1, 2'b10, 1'b0, 1'b1, 64'h0010);
    #3;
    chk("rst_hreadyout", 64'(mstHREADYOUT), 64'h1);
    chk("rst_hresp", 64'(mstHRESP), 64'h0);
    chk("rst_slvhsel", 64'(slvHSEL), 64'h0);
    chk("rst_can_switch", 64'(can_switch), 64'h1F);
    #9;
    HRESET = 1'b0;

    // decode / can_switch table with HREADY low so the FSM stays in IDLE
    hready_low = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive(vecs[i].hsel, vecs[i].trans, 1'b0, vecs[i].lock, vecs[i].addr);
      @(negedge HCLK);
      chk($sformatf("vec%0d_slvhsel", i), 64'(slvHSEL), 64'(vecs[i].exp_sel));
      chk($sformatf("vec%0d_can_switch", i), 64'(can_switch), 64'(vecs[i].exp_cs));
      chk($sformatf("vec%0d_slvhaddr", i), slvHADDR, vecs[i].addr);
    end
    next_cycle();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 64'h0);
    hready_low = 1'b0;

    // granted single write to slave 2
    granted_master = 5'b00100;
    next_cycle();
    drive(1'b1, 2'b10, 1'b1, 1'b0, 64'h2004);
    @(negedge HCLK);
    chk("wr_slvhsel", 64'(slvHSEL), 64'h04);
    chk("wr_addr_ready", 64'(mstHREADYOUT), 64'h1);
    next_cycle();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 64'h0);
    mstHWDATA = 64'hA5;
    @(negedge HCLK);
    chk("wr_slvhwdata", slvHWDATA, 64'hA5);
    chk("wr_data_ready", 64'(mstHREADYOUT), 64'h1);

    // ungranted read to slave 1: 3 stall cycles, one slave wait state, then grant
    granted_master = 5'b00000;
    next_cycle();
    drive(1'b1, 2'b10, 1'b0, 1'b0, 64'h1010);
    next_cycle();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 64'h3333);
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK);
      chk($sformatf("ug_stall%0d_ready", c), 64'(mstHREADYOUT), 64'h0);
      chk($sformatf("ug_stall%0d_addr", c), slvHADDR, 64'h1010);
      chk($sformatf("ug_stall%0d_sel", c), 64'(slvHSEL), 64'h02);
      next_cycle();
    end
    granted_master = 5'b00010;
    slvHREADY      = 5'b11101;
    @(negedge HCLK);
    chk("ug_slvwait_ready", 64'(mstHREADYOUT), 64'h0);
    chk("ug_slvwait_addr", slvHADDR, 64'h1010);
    next_cycle();
    slvHREADY = 5'b11111;
    @(negedge HCLK);
    chk("ug_grant_trans", 64'(slvHTRANS), 64'h2);
    chk("ug_grant_addr", slvHADDR, 64'h1010);
    chk("ug_grant_ready", 64'(mstHREADYOUT), 64'h0);
    next_cycle();
    @(negedge HCLK);
    chk("ug_rdata", mstHRDATA, 64'h1234);
    chk("ug_data_ready", 64'(mstHREADYOUT), 64'h1);

    // decode miss: two-cycle ERROR response
    next_cycle();
    drive(1'b1, 2'b10, 1'b0, 1'b0, 64'hF000);
    next_cycle();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 64'h0);
    @(negedge HCLK);
    chk("err1_ready", 64'(mstHREADYOUT), 64'h0);
    chk("err1_resp", 64'(mstHRESP), 64'h1);
    next_cycle();
    @(negedge HCLK);
    chk("err2_ready", 64'(mstHREADYOUT), 64'h1);
    chk("err2_resp", 64'(mstHRESP), 64'h1);
    next_cycle();
    @(negedge HCLK);
    chk("err_done_ready", 64'(mstHREADYOUT), 64'h1);
    chk("err_done_resp", 64'(mstHRESP), 64'h0);

    // locked INCR4 burst to slave 0
    granted_master = 5'b00001;
    mstHBURST = 3'b011;
    for (int b = 0; b < 4; b++) begin
      next_cycle();
      drive(1'b1, (b == 0) ? 2'b10 : 2'b11, 1'b1, 1'b1, 64'(b * 8));
      @(negedge HCLK);
      chk($sformatf("burst_beat%0d_cs", b + 1), 64'(can_switch), 64'h1E);
      chk($sformatf("burst_beat%0d_sel", b + 1), 64'(slvHSEL), 64'h01);
    end
    next_cycle();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 64'h0);
    mstHBURST = 3'b000;
    @(negedge HCLK);
    chk("burst_end_cs", 64'(can_switch), 64'h1F);

    // reset asserted mid-WAIT: outputs return without a clock edge
    granted_master = 5'b00000;
    next_cycle();
    drive(1'b1, 2'b10, 1'b0, 1'b0, 64'h1020);
    next_cycle();
    @(negedge HCLK);
    chk("rw_wait_ready", 64'(mstHREADYOUT), 64'h0);
    chk("rw_wait_sel", 64'(slvHSEL), 64'h02);
    #1;
    HRESET = 1'b1;
    #1;
    chk("rw_rst_sel", 64'(slvHSEL), 64'h0);
    chk("rw_rst_ready", 64'(mstHREADYOUT), 64'h1);
    chk("rw_rst_cs", 64'(can_switch), 64'h1F);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 64'h1020);
    #1;
    HRESET = 1'b0;
    next_cycle();
    @(negedge HCLK);
    chk("rw_after_sel", 64'(slvHSEL), 64'h0);
    chk("rw_after_ready", 64'(mstHREADYOUT), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
